// File: rtl/tt_madhu_pkg.sv
// rtl/tt_madhu_pkg.sv - shared constants and FSM encoding for the UART transmitter
package tt_madhu_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 104;
    localparam int FIFO_DEPTH           = 4;
    localparam int FIFO_PTR_W           = 2;
    localparam int FIFO_CNT_W           = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/tt_madhu_sync_fifo.sv
// rtl/tt_madhu_sync_fifo.sv - 4-entry byte FIFO with sticky overflow flag
module tt_madhu_sync_fifo
    import tt_madhu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  pop_i,
    input  logic                  ovf_clr_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [FIFO_CNT_W-1:0] count_o,
    output logic                  overflow_o
);

    logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  full, empty, do_push, do_pop;

    assign full    = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop_i & ~empty;
    // A full FIFO still takes a push when the same cycle frees a slot.
    assign do_push = push_i & (~full | do_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (ovf_clr_i) begin
            overflow_d = 1'b0;
        end else if (push_i & ~do_push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o     = mem_q[rd_ptr_q];
    assign full_o     = full;
    assign empty_o    = empty;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/tt_um_madhu_uart_tx.sv
// rtl/tt_um_madhu_uart_tx.sv - strobe-fed UART transmitter with a 4-byte queue
module tt_um_madhu_uart_tx
    import tt_madhu_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic                  stb_s1_q, stb_s2_q, stb_s3_q;
    logic                  clr_s1_q, clr_s2_q;
    logic [1:0]            rel_q;
    logic                  armed_q;
    logic                  push;

    tx_state_e             state_q, state_d;
    logic [CW-1:0]         baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  pop, baud_done;

    logic [7:0]            head;
    logic                  fifo_full, fifo_empty, fifo_ovf;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  unused_bits;

    assign unused_bits = ^uio_in[7:2];

    // rel_q marks when stb_s2_q holds a real sample; armed_q then needs one
    // observed low so a strobe held high through reset never pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_s1_q <= 1'b0;
            stb_s2_q <= 1'b0;
            stb_s3_q <= 1'b0;
            clr_s1_q <= 1'b0;
            clr_s2_q <= 1'b0;
            rel_q    <= 2'b00;
            armed_q  <= 1'b0;
        end else begin
            stb_s1_q <= uio_in[0];
            stb_s2_q <= stb_s1_q;
            stb_s3_q <= stb_s2_q;
            clr_s1_q <= uio_in[1];
            clr_s2_q <= clr_s1_q;
            rel_q    <= {rel_q[0], 1'b1};
            armed_q  <= armed_q | (rel_q[1] & ~stb_s2_q);
        end
    end

    assign push = stb_s2_q & ~stb_s3_q & ena & armed_q;

    tt_madhu_sync_fifo #(.WIDTH(8)) u_fifo (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .push_i     (push),
        .data_i     (ui_in),
        .pop_i      (pop),
        .ovf_clr_i  (clr_s2_q),
        .data_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .overflow_o (fifo_ovf)
    );

    assign baud_done = (baud_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // tx is registered from the next state so the line changes exactly on state edges.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign uo_out  = {fifo_ovf, fifo_count, fifo_empty, fifo_full,
                      (state_q != ST_IDLE), tx_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_madhu_uart_tx.sv
// tb/tb_tt_um_madhu_uart_tx.sv - directed self-checking bench for tt_um_madhu_uart_tx
module tb_tt_um_madhu_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp;
    int n_bad;

    logic [7:0] rx_q[$];
    int         rx_ferr;

    tt_um_madhu_uart_tx #(.CLKS_PER_BIT(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line receiver: k=0 is the first low sample, bits sampled mid-period.
    initial begin : rx_monitor
        bit         active;
        int         cnt;
        logic [7:0] sh;
        active  = 0;
        cnt     = 0;
        sh      = 8'h00;
        rx_ferr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0;
            end else if (!active) begin
                if (uo_out[0] == 1'b0) begin
                    active = 1;
                    cnt    = 0;
                end
            end else begin
                cnt = cnt + 1;
                if (cnt >= 6 && cnt <= 34 && (cnt % 4) == 2) sh[(cnt - 6) / 4] = uo_out[0];
                if (cnt == 38) begin
                    if (uo_out[0] !== 1'b1) rx_ferr = rx_ferr + 1;
                    rx_q.push_back(sh);
                    active = 0;
                end
            end
        end
    end

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx - 1];
    endfunction

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        ui_in     = b;
        uio_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        uio_in[0] = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit timed_out);
        timed_out = 1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (uo_out[1] == 1'b0 && uo_out[3] == 1'b1) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (uo_out !== 8'h09) begin
            n_bad++;
            $display("FAIL reset_uo_out: got %h want 09", uo_out);
        end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (uo_out !== 8'h09) begin
            n_bad++;
            $display("FAIL post_reset_uo_out: got %h want 09", uo_out);
        end
        n_cmp++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_uio: got out=%h oe=%h want 00/00", uio_out, uio_oe);
        end
    endtask

    task automatic test_single;
        rx_q.delete();
        @(negedge clk);
        ui_in     = 8'hA5;
        uio_in[0] = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (uo_out[6:4] !== 3'd1 || uo_out[0] !== 1'b1 || uo_out[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL single_after_E3: got cnt=%0d tx=%b busy=%b want 1/1/0",
                     uo_out[6:4], uo_out[0], uo_out[1]);
        end
        @(negedge clk);
        uio_in[0] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            n_cmp++;
            if (uo_out[0] !== frame_bit(8'hA5, k / 4) || uo_out[1] !== 1'b1) begin
                n_bad++;
                $display("FAIL single_frame k=%0d: got tx=%b busy=%b want tx=%b busy=1",
                         k, uo_out[0], uo_out[1], frame_bit(8'hA5, k / 4));
            end
            @(negedge clk);
        end
        n_cmp++;
        if (uo_out[1] !== 1'b0 || uo_out[3] !== 1'b1 || uo_out[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL single_end: got busy=%b empty=%b tx=%b want 0/1/1",
                     uo_out[1], uo_out[3], uo_out[0]);
        end
        n_cmp++;
        if (rx_q.size() !== 1 || rx_q[0] !== 8'hA5) begin
            n_bad++;
            $display("FAIL single_rx: got n=%0d first=%h want 1/a5", rx_q.size(),
                     (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back;
        logic [19:0] exp;
        exp = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
        rx_q.delete();
        write_byte(8'h00);
        fork
            begin
                for (int k = 0; k < 80; k++) begin
                    n_cmp++;
                    if (uo_out[0] !== exp[k / 4] || uo_out[1] !== 1'b1) begin
                        n_bad++;
                        $display("FAIL b2b_frame k=%0d: got tx=%b busy=%b want tx=%b busy=1",
                                 k, uo_out[0], uo_out[1], exp[k / 4]);
                    end
                    @(negedge clk);
                end
                n_cmp++;
                if (uo_out[1] !== 1'b0 || uo_out[0] !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_end: got busy=%b tx=%b want 0/1", uo_out[1], uo_out[0]);
                end
            end
            begin
                repeat (10) @(negedge clk);
                write_byte(8'hFF);
            end
        join
        n_cmp++;
        if (rx_q.size() !== 2 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF) begin
            n_bad++;
            $display("FAIL b2b_rx: got n=%0d want 2 bytes 00,ff", rx_q.size());
        end
    endtask

    task automatic test_overflow;
        logic [7:0] vals [6];
        bit         to;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            write_byte(vals[i]);
            if (i < 5) @(negedge clk);
        end
        n_cmp++;
        if (uo_out[2] !== 1'b1 || uo_out[6:4] !== 3'd4 || uo_out[7] !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_full: got full=%b cnt=%0d ovf=%b want 1/4/1",
                     uo_out[2], uo_out[6:4], uo_out[7]);
        end
        uio_in[1] = 1'b1;
        repeat (4) @(negedge clk);
        uio_in[1] = 1'b0;
        n_cmp++;
        if (uo_out[7] !== 1'b0 || uo_out[6:4] !== 3'd4) begin
            n_bad++;
            $display("FAIL ovf_clear: got ovf=%b cnt=%0d want 0/4", uo_out[7], uo_out[6:4]);
        end
        wait_idle(1000, to);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (to !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_drain_timeout: got timeout=%b want 0", to);
        end
        n_cmp++;
        if (rx_q.size() !== 5) begin
            n_bad++;
            $display("FAIL ovf_rx_count: got %0d want 5", rx_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) begin
                n_cmp++;
                if (rx_q[i] !== vals[i]) begin
                    n_bad++;
                    $display("FAIL ovf_rx_byte%0d: got %h want %h", i, rx_q[i], vals[i]);
                end
            end
        end
    endtask

    task automatic test_ena_gating;
        bit to;
        ena = 1'b0;
        write_byte(8'h3C);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (uo_out[6:4] !== 3'd0 || uo_out[3] !== 1'b1 || uo_out[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL ena_off_push: got cnt=%0d empty=%b busy=%b want 0/1/0",
                     uo_out[6:4], uo_out[3], uo_out[1]);
        end
        ena = 1'b1;
        rx_q.delete();
        write_byte(8'hC3);
        n_cmp++;
        if (uo_out[1] !== 1'b1 || uo_out[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL ena_start: got busy=%b tx=%b want 1/0", uo_out[1], uo_out[0]);
        end
        repeat (10) @(negedge clk);
        ena = 1'b0;
        wait_idle(200, to);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (to !== 1'b0 || rx_q.size() !== 1 || rx_q[0] !== 8'hC3) begin
            n_bad++;
            $display("FAIL ena_drop_frame: got timeout=%b n=%0d want 0/1 byte c3",
                     to, rx_q.size());
        end
        ena = 1'b1;
    endtask

    task automatic test_reset_mid_frame;
        bit stayed_high;
        rx_q.delete();
        write_byte(8'h37);
        repeat (18) @(negedge clk);
        n_cmp++;
        if (uo_out[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_bit3: got tx=%b want 0", uo_out[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (uo_out !== 8'h09) begin
            n_bad++;
            $display("FAIL rst_mid_async: got %h want 09", uo_out);
        end
        repeat (3) @(negedge clk);
        rst_n       = 1'b1;
        stayed_high = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uo_out[0] !== 1'b1 || uo_out[1] !== 1'b0) stayed_high = 0;
        end
        n_cmp++;
        if (stayed_high !== 1'b1 || rx_q.size() !== 0 || uo_out[3] !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_quiet: got high=%b n=%0d empty=%b want 1/0/1",
                     stayed_high, rx_q.size(), uo_out[3]);
        end
    endtask

    task automatic test_held_strobe;
        bit to;
        @(negedge clk);
        ui_in     = 8'h77;
        uio_in[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (uo_out !== 8'h09) begin
            n_bad++;
            $display("FAIL held_strobe_push: got %h want 09", uo_out);
        end
        uio_in[0] = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (uo_out !== 8'h09) begin
            n_bad++;
            $display("FAIL held_strobe_fall: got %h want 09", uo_out);
        end
        rx_q.delete();
        write_byte(8'h5A);
        wait_idle(200, to);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (to !== 1'b0 || rx_q.size() !== 1 || rx_q[0] !== 8'h5A) begin
            n_bad++;
            $display("FAIL held_strobe_fresh: got timeout=%b n=%0d want 0/1 byte 5a",
                     to, rx_q.size());
        end
    endtask

    task automatic test_static;
        n_cmp++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            n_bad++;
            $display("FAIL static_uio: got out=%h oe=%h want 00/00", uio_out, uio_oe);
        end
        n_cmp++;
        if (rx_ferr !== 0) begin
            n_bad++;
            $display("FAIL stop_bits: got %0d framing errors want 0", rx_ferr);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_ena_gating();
        test_reset_mid_frame();
        test_held_strobe();
        test_static();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
